sdf_2f_unpick: RTL and testbench

Downstream companion of the two-flow pick/accumulate actor. It consumes the tagged stream that actor writes: the MSB is the flow tag and the lower `WIDTH-1` bits are the running sum. It strips the tag and routes each word to one of two output FIFOs through a one-entry registered slot per flow. It also tracks each flow's position within its 4-element accumulation group.

---
 rtl/sdf_2f_unpick.sv | 140 ++++++++++++++
 tb/tb_sdf_2f_unpick.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_2f_unpick.sv
// sdf_2f_unpick
//
// Downstream companion of the two-flow pick/accumulate actor. Each input word
// carries a flow tag in its MSB and a running sum in the remaining bits. The
// tag is stripped and the sum is routed to one of two output FIFOs through a
// one-entry registered slot per flow. A 2-bit counter per flow tracks the
// word's position inside its 4-word accumulation group. The slot's last flag
// marks the 4th word of a group.
//
// Configuration macro:
//   SDF_UNPICK_LAST_ONLY_EN - when defined, only the 4th word of each group
//                             (the completed sum) is forwarded. The other
//                             words are popped and counted, then discarded.
//
// Ports:
//   ck          clock, rising edge
//   rst         asynchronous active-high reset
//   in_data     head word of the input FIFO (first-word-fall-through)
//   in_empty    input FIFO empty
//   in_read     pop strobe to the input FIFO (combinational)
//   out0_full   flow-0 output FIFO full
//   out0_wr     flow-0 write strobe (combinational)
//   out0_data   flow-0 payload (registered)
//   out1_full   flow-1 output FIFO full
//   out1_wr     flow-1 write strobe (combinational)
//   out1_data   flow-1 payload (registered)
//   grp0_last   slot 0 holds the 4th word of its group (registered)
//   grp1_last   slot 1 holds the 4th word of its group (registered)

module sdf_2f_unpick #(
  parameter int WIDTH = 8
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_empty,
  output logic             in_read,
  input  logic             out0_full,
  output logic             out0_wr,
  output logic [WIDTH-2:0] out0_data,
  input  logic             out1_full,
  output logic             out1_wr,
  output logic [WIDTH-2:0] out1_data,
  output logic             grp0_last,
  output logic             grp1_last
);

  localparam int PW = WIDTH - 1;

  logic          v0, v1;
  logic          l0, l1;
  logic [PW-1:0] d0, d1;
  logic [1:0]    c0, c1;

  logic          tag;
  logic [PW-1:0] payload;
  logic          free0, free1, slot_free;
  logic [1:0]    cnt_t;
  logic          last_word;
  logic          accept, load_word;
  logic          adv0, adv1, load0, load1;

  // Accept/load decision for the head word. A slot counts as free when it is
  // empty or when it is being written out this very cycle. This lets a new
  // word replace a draining one and sustain one word per cycle. Only the
  // tagged flow's slot matters. A blocked head word stalls the whole input,
  // which keeps the words in order. The reset term holds the pop strobe low
  // while reset is asserted.
  always_comb begin
    tag       = in_data[WIDTH-1];
    payload   = in_data[WIDTH-2:0];
    free0     = ~v0 | ~out0_full;
    free1     = ~v1 | ~out1_full;
    slot_free = tag ? free1 : free0;
    cnt_t     = tag ? c1 : c0;
    last_word = (cnt_t == 2'd3);
`ifdef SDF_UNPICK_LAST_ONLY_EN
    // Partial sums never occupy the slot, so popping them needs no space.
    accept    = ~rst & ~in_empty & (~last_word | slot_free);
    load_word = accept & last_word;
`else
    accept    = ~rst & ~in_empty & slot_free;
    load_word = accept;
`endif
    adv0  = accept & ~tag;
    adv1  = accept & tag;
    load0 = load_word & ~tag;
    load1 = load_word & tag;
  end

  assign in_read   = accept;
  assign out0_wr   = v0 & ~out0_full;
  assign out1_wr   = v1 & ~out1_full;
  assign out0_data = d0;
  assign out1_data = d1;
  assign grp0_last = l0;
  assign grp1_last = l1;

  // Slot 0 and group counter 0. If a load and a drain happen in the same
  // cycle, the load wins. The payload register keeps its value after a drain.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      l0 <= 1'b0;
      d0 <= '0;
      c0 <= 2'd0;
    end else begin
      if (adv0)
        c0 <= c0 + 2'd1;
      if (load0) begin
        v0 <= 1'b1;
        d0 <= payload;
        l0 <= last_word;
      end else if (out0_wr) begin
        v0 <= 1'b0;
      end
    end
  end

  // Slot 1 and group counter 1. This block mirrors slot 0.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      l1 <= 1'b0;
      d1 <= '0;
      c1 <= 2'd0;
    end else begin
      if (adv1)
        c1 <= c1 + 2'd1;
      if (load1) begin
        v1 <= 1'b1;
        d1 <= payload;
        l1 <= last_word;
      end else if (out1_wr) begin
        v1 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sdf_2f_unpick.sv
// tb_sdf_2f_unpick
//
// Testbench for sdf_2f_unpick with WIDTH=8. Directed scenarios cover the
// operating mode selected by SDF_UNPICK_LAST_ONLY_EN. A randomized run then
// compares the DUT against a queue-based reference: every popped word is
// appended to its flow's expected output queue, and every write must match
// the front of that queue.

module tb_sdf_2f_unpick;

  logic       ck = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_empty;
  logic       in_read;
  logic       out0_full, out1_full;
  logic       out0_wr, out1_wr;
  logic [6:0] out0_data, out1_data;
  logic       grp0_last, grp1_last;

  int checks = 0;
  int errors = 0;

  sdf_2f_unpick #(.WIDTH(8)) dut (
    .ck        (ck),
    .rst       (rst),
    .in_data   (in_data),
    .in_empty  (in_empty),
    .in_read   (in_read),
    .out0_full (out0_full),
    .out0_wr   (out0_wr),
    .out0_data (out0_data),
    .out1_full (out1_full),
    .out1_wr   (out1_wr),
    .out1_data (out1_data),
    .grp0_last (grp0_last),
    .grp1_last (grp1_last)
  );

  always #5 ck = ~ck;

  // Reset with an idle input. The task returns just after a rising edge so
  // callers can drive the next cycle's inputs straight away.
  task automatic do_reset();
    rst = 1'b1;
    in_empty = 1'b1;
    in_data = 8'h00;
    out0_full = 1'b0;
    out1_full = 1'b0;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_empty = 1'b0;
    in_data = 8'h05;
    out0_full = 1'b0;
    out1_full = 1'b0;
    @(posedge ck);
    @(negedge ck);
    checks++;
    if ({in_read, out0_wr, out1_wr, out0_data, out1_data, grp0_last, grp1_last} !== 19'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {in_read, out0_wr, out1_wr, out0_data, out1_data, grp0_last, grp1_last});
    end
    do_reset();
  endtask

`ifndef SDF_UNPICK_LAST_ONLY_EN
  task automatic test_routing();
    do_reset();
    in_data = 8'h05; in_empty = 1'b0;
    @(negedge ck);
    checks++;
    if (in_read !== 1'b1) begin
      errors++; $display("[TB] FAIL route_pop0: in_read got %b expected 1", in_read);
    end
    @(posedge ck); #1 in_data = 8'h85;
    @(negedge ck);
    checks++;
    if ({in_read, out0_wr, out0_data, out1_wr} !== {1'b1, 1'b1, 7'h05, 1'b0}) begin
      errors++; $display("[TB] FAIL route_flow0: got %h expected %h",
                         {in_read, out0_wr, out0_data, out1_wr}, {1'b1, 1'b1, 7'h05, 1'b0});
    end
    @(posedge ck); #1 in_empty = 1'b1;
    @(negedge ck);
    checks++;
    if ({in_read, out0_wr, out1_wr, out1_data} !== {1'b0, 1'b0, 1'b1, 7'h05}) begin
      errors++; $display("[TB] FAIL route_flow1: got %h expected %h",
                         {in_read, out0_wr, out1_wr, out1_data}, {1'b0, 1'b0, 1'b1, 7'h05});
    end
    @(posedge ck); #1;
  endtask

  task automatic test_group_counter();
    logic [7:0] w [5];
    w = '{8'h01, 8'h03, 8'h06, 8'h0A, 8'h02};
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin in_data = w[i]; in_empty = 1'b0; end
      else in_empty = 1'b1;
      @(negedge ck);
      if (i < 5) begin
        checks++;
        if (in_read !== 1'b1) begin
          errors++; $display("[TB] FAIL group_pop%0d: in_read got %b expected 1", i, in_read);
        end
      end
      if (i > 0) begin
        checks++;
        if ({out0_wr, out0_data, grp0_last} !== {1'b1, w[i-1][6:0], (i == 4)}) begin
          errors++; $display("[TB] FAIL group_word%0d: got %h expected %h", i - 1,
                             {out0_wr, out0_data, grp0_last}, {1'b1, w[i-1][6:0], (i == 4)});
        end
      end
      @(posedge ck); #1;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      if (i < 4) begin in_data = 8'h10 + 8'(i); in_empty = 1'b0; end
      else in_empty = 1'b1;
      @(negedge ck);
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({out0_wr, out0_data} !== {1'b1, 7'h10 + 7'(i - 1)}) begin
          errors++; $display("[TB] FAIL b2b_cycle%0d: got %h expected %h", i,
                             {out0_wr, out0_data}, {1'b1, 7'h10 + 7'(i - 1)});
        end
      end else if (i == 5) begin
        checks++;
        if (out0_wr !== 1'b0) begin
          errors++; $display("[TB] FAIL b2b_idle: out0_wr got %b expected 0", out0_wr);
        end
      end
      @(posedge ck); #1;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out1_full = 1'b1; in_data = 8'h81; in_empty = 1'b0;
    @(negedge ck);
    checks++;
    if (in_read !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_pop81: in_read got %b expected 1", in_read);
    end
    @(posedge ck); #1 in_data = 8'h07;
    @(negedge ck);
    checks++;
    if ({in_read, out1_wr, out1_data} !== {1'b1, 1'b0, 7'h01}) begin
      errors++; $display("[TB] FAIL bp_other_flow: got %h expected %h",
                         {in_read, out1_wr, out1_data}, {1'b1, 1'b0, 7'h01});
    end
    @(posedge ck); #1 in_data = 8'h82;
    @(negedge ck);
    checks++;
    if ({in_read, out0_wr, out0_data, out1_wr} !== {1'b0, 1'b1, 7'h07, 1'b0}) begin
      errors++; $display("[TB] FAIL bp_hol_block: got %h expected %h",
                         {in_read, out0_wr, out0_data, out1_wr}, {1'b0, 1'b1, 7'h07, 1'b0});
    end
    @(posedge ck); #1;
    @(negedge ck);
    checks++;
    if ({in_read, out0_wr, out1_wr, out1_data} !== {1'b0, 1'b0, 1'b0, 7'h01}) begin
      errors++; $display("[TB] FAIL bp_hold: got %h expected %h",
                         {in_read, out0_wr, out1_wr, out1_data}, {1'b0, 1'b0, 1'b0, 7'h01});
    end
    @(posedge ck); #1 out1_full = 1'b0;
    @(negedge ck);
    checks++;
    if ({in_read, out1_wr, out1_data} !== {1'b1, 1'b1, 7'h01}) begin
      errors++; $display("[TB] FAIL bp_release: got %h expected %h",
                         {in_read, out1_wr, out1_data}, {1'b1, 1'b1, 7'h01});
    end
    @(posedge ck); #1 in_empty = 1'b1;
    @(negedge ck);
    checks++;
    if ({out1_wr, out1_data} !== {1'b1, 7'h02}) begin
      errors++; $display("[TB] FAIL bp_after: got %h expected %h", {out1_wr, out1_data}, {1'b1, 7'h02});
    end
    @(posedge ck); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out0_full = 1'b1;
    in_data = 8'h81; in_empty = 1'b0;
    @(posedge ck); #1 in_data = 8'h82;
    @(posedge ck); #1 in_data = 8'h03;
    @(posedge ck); #1 in_empty = 1'b1;
    @(negedge ck);
    checks++;
    if ({out0_wr, out0_data} !== {1'b0, 7'h03}) begin
      errors++; $display("[TB] FAIL mid_held: got %h expected %h", {out0_wr, out0_data}, {1'b0, 7'h03});
    end
    out0_full = 1'b0; in_data = 8'h81; in_empty = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({in_read, out0_wr, out1_wr, out0_data, out1_data, grp0_last, grp1_last} !== 19'h0) begin
      errors++; $display("[TB] FAIL mid_reset: got %h expected 0",
                         {in_read, out0_wr, out1_wr, out0_data, out1_data, grp0_last, grp1_last});
    end
    @(posedge ck); #1 rst = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin in_data = 8'h81 + 8'(i); in_empty = 1'b0; end
      else in_empty = 1'b1;
      @(negedge ck);
      if (i > 0) begin
        checks++;
        if ({out1_wr, grp1_last, out1_data} !== {1'b1, (i == 4), 7'(i)}) begin
          errors++; $display("[TB] FAIL mid_group%0d: got %h expected %h", i,
                             {out1_wr, grp1_last, out1_data}, {1'b1, (i == 4), 7'(i)});
        end
      end
      @(posedge ck); #1;
    end
  endtask
`else
  task automatic test_last_only();
    logic [7:0] w [4];
    w = '{8'h01, 8'h03, 8'h06, 8'h0A};
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      if (i < 4) begin in_data = w[i]; in_empty = 1'b0; end
      else in_empty = 1'b1;
      @(negedge ck);
      if (i < 4) begin
        checks++;
        if (in_read !== 1'b1) begin
          errors++; $display("[TB] FAIL lo_pop%0d: in_read got %b expected 1", i, in_read);
        end
      end
      if (i > 0) begin
        checks++;
        if (out0_wr !== (i == 4)) begin
          errors++; $display("[TB] FAIL lo_wr%0d: out0_wr got %b expected %b", i, out0_wr, (i == 4));
        end
      end
      if (i == 4) begin
        checks++;
        if ({out0_data, grp0_last} !== {7'h0A, 1'b1}) begin
          errors++; $display("[TB] FAIL lo_sum: got %h expected %h", {out0_data, grp0_last}, {7'h0A, 1'b1});
        end
      end
      @(posedge ck); #1;
    end
  endtask
`endif

  // Randomized traffic with random backpressure and input gaps. Each expected
  // queue entry is {last flag, payload}. The last flag comes from the flow's
  // word count modulo 4.
  task automatic test_random();
    logic [7:0] in_q[$];
    logic [7:0] eq0[$];
    logic [7:0] eq1[$];
    int cnt[2];
    int cycles;
    logic t, full_t, exp_rd, exp_wr0, exp_wr1, fwd;
    int occ_t;
    logic [7:0] w;
    do_reset();
    cnt[0] = 0; cnt[1] = 0;
    for (int n = 0; n < 400; n++) in_q.push_back(8'($urandom));
    cycles = 0;
    while ((in_q.size() > 0 || eq0.size() > 0 || eq1.size() > 0) && cycles < 5000) begin
      out0_full = ($urandom_range(0, 3) == 0);
      out1_full = ($urandom_range(0, 3) == 0);
      in_empty  = ($urandom_range(0, 4) == 0) || (in_q.size() == 0);
      in_data   = (in_q.size() > 0) ? in_q[0] : 8'($urandom);
      @(negedge ck);
      t      = in_data[7];
      occ_t  = t ? eq1.size() : eq0.size();
      full_t = t ? out1_full : out0_full;
`ifdef SDF_UNPICK_LAST_ONLY_EN
      exp_rd = !in_empty && (cnt[t] != 3 || occ_t == 0 || !full_t);
`else
      exp_rd = !in_empty && (occ_t == 0 || !full_t);
`endif
      exp_wr0 = (eq0.size() > 0) && !out0_full;
      exp_wr1 = (eq1.size() > 0) && !out1_full;
      checks++;
      if (in_read !== exp_rd) begin
        errors++; $display("[TB] FAIL rand_in_read@%0d: got %b expected %b", cycles, in_read, exp_rd);
      end
      checks++;
      if (out0_wr !== exp_wr0) begin
        errors++; $display("[TB] FAIL rand_out0_wr@%0d: got %b expected %b", cycles, out0_wr, exp_wr0);
      end
      checks++;
      if (out1_wr !== exp_wr1) begin
        errors++; $display("[TB] FAIL rand_out1_wr@%0d: got %b expected %b", cycles, out1_wr, exp_wr1);
      end
      if (exp_wr0) begin
        checks++;
        if ({grp0_last, out0_data} !== eq0[0]) begin
          errors++; $display("[TB] FAIL rand_out0_word@%0d: got %h expected %h", cycles,
                             {grp0_last, out0_data}, eq0[0]);
        end
        void'(eq0.pop_front());
      end
      if (exp_wr1) begin
        checks++;
        if ({grp1_last, out1_data} !== eq1[0]) begin
          errors++; $display("[TB] FAIL rand_out1_word@%0d: got %h expected %h", cycles,
                             {grp1_last, out1_data}, eq1[0]);
        end
        void'(eq1.pop_front());
      end
      if (exp_rd) begin
        w = in_q.pop_front();
`ifdef SDF_UNPICK_LAST_ONLY_EN
        fwd = (cnt[t] == 3);
`else
        fwd = 1'b1;
`endif
        if (fwd) begin
          if (t) eq1.push_back({cnt[t] == 3, w[6:0]});
          else   eq0.push_back({cnt[t] == 3, w[6:0]});
        end
        cnt[t] = (cnt[t] + 1) % 4;
      end
      @(posedge ck); #1;
      cycles++;
    end
    if (cycles >= 5000) begin
      checks++; errors++;
      $display("[TB] FAIL rand_timeout: cycles got %0d expected below 5000", cycles);
    end
    out0_full = 1'b0;
    out1_full = 1'b0;
    in_empty = 1'b1;
  endtask

  initial begin
    test_reset();
`ifndef SDF_UNPICK_LAST_ONLY_EN
    test_routing();
    test_group_counter();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`else
    test_last_only();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
